uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_tx_fifo_drain.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains words from a ring FIFO that has no empty flag and
// transmits each one as an asynchronous serial frame (start, data LSB-first,
// optional even parity, stop bits).
//
// Optional feature: define UART_TX_FIFO_DRAIN_PARITY_EN to insert an even parity
// bit between the data bits and the stop bits.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous reset, active-low
//   enable     1 = allowed to start new frames
//   fifo_read  read strobe to FIFO, one-cycle pulse (registered)
//   fifo_data  FIFO output word, valid when fifo_val=1
//   fifo_val   FIFO read-valid, one cycle after an accepted read
//   tx         serial line, idles high (registered)
//   busy       high from first start-bit cycle to last stop-bit cycle (registered)
//   frame_done one-cycle pulse on the last cycle of the final stop bit (registered)
module uart_tx_fifo_drain #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_val,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                baud_end;
  logic                fifo_read_d, tx_d, busy_d, frame_done_d;

  assign baud_end = (baud_q == BAUD_LAST);

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      fifo_read  <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      fifo_read  <= fifo_read_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  // Next state, next counters, and next output values derived from them
  always_comb begin
    state_d      = state_q;
    baud_d       = '0;
    bit_d        = bit_q;
    shift_d      = shift_q;
    fifo_read_d  = 1'b0;
    tx_d         = 1'b1;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (enable) state_d = REQ;
      end
      REQ: begin
        bit_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        bit_d = '0;
        if (fifo_val) begin
          shift_d = fifo_data;
          state_d = START;
        end else if (enable) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) begin
          // Rotate rather than shift so the word is intact again for parity
          shift_d = {shift_q[0], shift_q[DATA_W-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
      PARITY: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) state_d = STOP;
      end
`endif
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = enable ? REQ : IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state will drive
    fifo_read_d  = (state_d == REQ);
    busy_d       = !(state_d inside {IDLE, REQ, WAIT});
    frame_done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
      PARITY:  tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: ring-FIFO model, serial frame scoreboard built
// from the frame format, directed scenarios followed by randomized traffic.
module tb_uart_tx_fifo_drain;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_FIFO_DRAIN_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned NBITS     = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int unsigned FRAME_CYC = NBITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_read;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_val = 1'b0;
  logic       tx, busy, frame_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .STOP_BITS(STOP_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .fifo_val   (fifo_val),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ring FIFO model: registered valid one cycle after an accepted read
  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] w_pop;
  int reads = 0;
  int pops  = 0;

  always @(posedge clk) begin
    fifo_val <= 1'b0;
    if (fifo_read) begin
      reads++;
      if (fifo_q.size() > 0) begin
        w_pop = fifo_q.pop_front();
        fifo_data <= w_pop;
        fifo_val  <= 1'b1;
        sent_q.push_back(w_pop);
        pops++;
      end
    end
  end

  // Serial monitor: captures a whole frame from the start edge, then compares
  // it against the frame the popped word should produce.
  int          pos = -1;
  int          frames = 0;
  int          fd_cnt = 0;
  int          aborts = 0;
  int          gap = 0;
  int          gaps_q[$];
  logic [7:0]  last_word = 8'h00;
  logic        prev_read = 1'b0;
  logic [63:0] cap_tx, cap_busy, cap_fd;

  task automatic check_frame();
    logic [7:0]  w;
    logic [63:0] exp_tx;
    logic        v;
    int          b;
    chk("frame_pending", 64'(sent_q.size()), 64'd1);
    if (sent_q.size() == 0) return;
    w = sent_q.pop_front();
    exp_tx = '0;
    for (int c = 0; c < int'(FRAME_CYC); c++) begin
      b = c / int'(CLK_DIV);
      if (b == 0)                                      v = 1'b0;
      else if (b <= int'(DATA_W))                      v = w[b-1];
      else if (PAR_BITS != 0 && b == int'(DATA_W) + 1) v = ^w;
      else                                             v = 1'b1;
      exp_tx[c] = v;
    end
    chk("frame_tx", cap_tx, exp_tx);
    chk("frame_busy", cap_busy, (64'd1 << FRAME_CYC) - 64'd1);
    chk("frame_done_pos", cap_fd, 64'd1 << (FRAME_CYC - 1));
    frames++;
    last_word = w;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (pos >= 0 && sent_q.size() > 0) begin
        void'(sent_q.pop_front());
        aborts++;
      end
      pos = -1;
      gap = 0;
      prev_read = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (pos < 0 && tx == 1'b0) begin
        pos = 0;
        cap_tx = '0; cap_busy = '0; cap_fd = '0;
        gaps_q.push_back(gap);
      end
      if (pos >= 0) begin
        cap_tx[pos] = tx; cap_busy[pos] = busy; cap_fd[pos] = frame_done;
        pos++;
        if (pos == int'(FRAME_CYC)) begin
          check_frame();
          pos = -1;
          gap = 0;
        end
      end else begin
        gap++;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_frame_done", 64'(frame_done), 64'd0);
      end
      if (fifo_read) begin
        chk("read_while_busy", 64'(busy), 64'd0);
        chk("read_back_to_back", 64'(prev_read), 64'd0);
      end
      prev_read = fifo_read;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("frames_reached", 64'(frames), 64'(target));
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while (pos != p && k < 400) begin
      tick(1);
      k++;
    end
    chk("pos_reached", 64'(pos), 64'(p));
  endtask

  int r0, f0, d0, k;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_read", 64'(fifo_read), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("no_read_disabled", 64'(reads), 64'd0);

    // Single word 0xA5
    fifo_q.push_back(8'hA5);
    enable = 1'b1;
    wait_frames(1, 200);
    enable = 1'b0;
    tick(4);
    chk("single_pops", 64'(pops), 64'd1);
    chk("single_done_cnt", 64'(fd_cnt), 64'd1);
    chk("single_word", 64'(last_word), 64'hA5);

    // Empty FIFO probing for 20 cycles
    r0 = reads; f0 = frames; d0 = fd_cnt;
    enable = 1'b1;
    tick(20);
    enable = 1'b0;
    tick(4);
    chk("empty_reads", 64'(reads - r0), 64'd10);
    chk("empty_frames", 64'(frames - f0), 64'd0);
    chk("empty_done", 64'(fd_cnt - d0), 64'd0);
    chk("empty_tx", 64'(tx), 64'd1);

    // Burst of three words, two idle cycles between frames
    gaps_q.delete();
    f0 = frames; d0 = fd_cnt;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h80);
    fifo_q.push_back(8'hFF);
    enable = 1'b1;
    wait_frames(f0 + 3, 500);
    enable = 1'b0;
    tick(4);
    chk("burst_gap_count", 64'(gaps_q.size()), 64'd3);
    if (gaps_q.size() == 3) begin
      chk("burst_gap1", 64'(gaps_q[1]), 64'd2);
      chk("burst_gap2", 64'(gaps_q[2]), 64'd2);
    end
    chk("burst_done", 64'(fd_cnt - d0), 64'd3);
    chk("burst_last_word", 64'(last_word), 64'hFF);

    // enable dropped during data of 0x3C with 0x55 queued
    f0 = frames;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h55);
    enable = 1'b1;
    wait_pos(12);
    enable = 1'b0;
    wait_frames(f0 + 1, 200);
    r0 = reads;
    tick(10);
    chk("drop_word", 64'(last_word), 64'h3C);
    chk("drop_no_reads", 64'(reads - r0), 64'd0);
    chk("drop_fifo_left", 64'(fifo_q.size()), 64'd1);
    if (fifo_q.size() == 1) chk("drop_fifo_head", 64'(fifo_q[0]), 64'h55);
    chk("drop_tx_idle", 64'(tx), 64'd1);

    // Reset during data bit 3 of 0x55, then next word after release
    enable = 1'b1;
    wait_pos(17);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 64'(tx), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_fifo_read", 64'(fifo_read), 64'd0);
    tick(3);
    fifo_q.push_back(8'h66);
    f0 = frames;
    rst_n = 1'b1;
    wait_frames(f0 + 1, 200);
    chk("arst_next_word", 64'(last_word), 64'h66);
    enable = 1'b0;
    tick(4);

    // Randomized traffic and enable toggling
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      tick(1);
    end
    enable = 1'b1;
    k = 0;
    while ((fifo_q.size() != 0 || sent_q.size() != 0 || pos >= 0) && k < 3000) begin
      tick(1);
      k++;
    end
    enable = 1'b0;
    tick(6);
    chk("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
    chk("rand_pops_eq_frames", 64'(pops - aborts), 64'(frames));
    chk("rand_done_eq_frames", 64'(fd_cnt), 64'(frames));
    chk("rand_tx_idle", 64'(tx), 64'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
